fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares one 8-entry × 4-bit synchronous FIFO (`sync_fifo`) among `N_REQ` producers. It grants write ownership to one requester at a time for bursts of up to `BURST_LEN` words. It drives the FIFO's `wr_en`/`data_in` and never writes when the FIFO is full. It sits between the producer blocks and the FIFO write side; the read side is untouched.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `BURST_LEN`, 2: maximum words per ownership (1..8).
- `MIN_FREE`, 1: free entries required to start a burst (1..8).
- `clk` in 1: single clock, all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req` in `N_REQ`: bit i high = requester i has a valid word on its data lane; held until granted.
- `req_data` in `N_REQ*4`: lane i = bits [4i+3:4i].
- `gnt` out `N_REQ`: one-hot or zero; bit i high = lane i written into the FIFO this cycle.
- `fifo_wr_en` out 1: to FIFO `wr_en`.
- `fifo_data_in` out 4: to FIFO `data_in`; 0 when `fifo_wr_en` is low.
- `fifo_full` in 1: from FIFO `full`.
- `fifo_count` in 4: from FIFO `count` (registered, 0..8).
- `owner` out `$clog2(N_REQ)`: current or last burst owner.
- `busy` out 1: high in state BURST.

## Operation
- States:
  - IDLE: no owner.
  - BURST: `owner` holds the write port.
- Registers: `state`, `owner`, `rr_ptr` (next-priority index), `burst_cnt` (0..`BURST_LEN`).
- IDLE:
  - Winner = first i with `req[i]`, searching `rr_ptr`, `rr_ptr+1`, … mod `N_REQ`.
  - Start a burst only if a winner exists, `!fifo_full` and `fifo_count <= 8-MIN_FREE`.
  - On start: write the winner's word this cycle (`gnt[w]`, `fifo_wr_en`), `owner<=w`, `burst_cnt<=1`.
  - If `BURST_LEN==1`: stay IDLE, `rr_ptr<=w+1`. Otherwise go to BURST.
- BURST:
  - `req[owner] && !fifo_full`: write, `burst_cnt++`. If the new count equals `BURST_LEN`, go to IDLE with `rr_ptr<=owner+1`.
  - `req[owner] && fifo_full`: stall. No write, no count change, stay in BURST. No timeout.
  - `!req[owner]`: release. No write, go to IDLE with `rr_ptr<=owner+1`. This costs one bubble cycle.
  - Requests from non-owners are ignored during BURST.
- `fifo_wr_en` is never high while `fifo_full` is high, or while `reset` is high.
- `gnt` is exactly `fifo_wr_en` decoded to the written lane.
- Index arithmetic wraps modulo `N_REQ`. `owner+1` wraps to 0 when `N_REQ` is not a power of two.

## Timing
- Reset values: `state`=IDLE, `owner`=0, `rr_ptr`=0, `burst_cnt`=0, `gnt`=0, `fifo_wr_en`=0, `fifo_data_in`=0, `busy`=0.
- `gnt`, `fifo_wr_en` and `fifo_data_in` are combinational from state and the current-cycle `req`/`req_data`/`fifo_full`/`fifo_count`. Zero latency: a word is accepted in the cycle `gnt` is high.
- Requester handshake:
  - Data must be stable while `req` is high and `gnt` is low.
  - After `gnt`, the requester may present the next word the following cycle.
- Burst limit reached: the next owner can write in the very next cycle. Back-to-back bursts have no bubble.
- `fifo_count` lags writes by one cycle. `MIN_FREE` is checked only at burst start. Inside a burst, `fifo_full` is the only back-pressure.
- Reset mid-burst: the write in the reset cycle is suppressed. The next cycle is IDLE with `rr_ptr`=0.

## Structure
- Package `fifo_arb_pkg`:
  - `FIFO_DEPTH=8`, `DATA_W=4`, `CNT_W=4`.
  - `typedef enum logic {IDLE, BURST} arb_state_t`.
- Sub-module `rr_picker`: combinational; inputs `req` and `rr_ptr`, outputs `valid` and winner index. Rotate, priority-encode, un-rotate.
- Top level holds the FSM, counters and output muxing. Target 150–250 lines.

## Test plan
- Single requester: `req[2]`=1 with data 0xA then 0xB, all others idle, `BURST_LEN`=2.
  - Expect `gnt`=0100 for 2 consecutive cycles, FIFO receives A,B, then 1 IDLE cycle with `rr_ptr`=3.
- All four request continuously from reset, lane i data = i, `BURST_LEN`=2, no reads.
  - Expect FIFO sequence 0,0,1,1,2,2,3,3 in 8 consecutive cycles, then `fifo_full`=1 and `gnt`=0.
- FIFO full mid-burst: prefill 7 words, owner 1 requests 2 words.
  - Expect 1 write, then a stall with `busy`=1 and `gnt`=0.
  - One read frees an entry; the 2nd word is written the next cycle and the burst completes.
- Early release: owner 0 drops `req` after 1 word while `req[1]`=1, `BURST_LEN`=4.
  - Expect a 1-cycle bubble, then requester 1 is granted.
- Reset mid-burst: assert `reset` in the 2nd burst cycle.
  - Expect `fifo_wr_en`=0 that cycle, then IDLE with `rr_ptr`=0 and `gnt`=0 while `reset` is high.
- `MIN_FREE`=3, `fifo_count`=6, `req[0]`=1.
  - Expect no grant.
  - After reads bring `fifo_count` to 5, the grant occurs in the same cycle `fifo_count` reads 5.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared constants and types for the FIFO write-port arbiter.
//   FIFO_DEPTH : entries in the downstream sync_fifo
//   DATA_W     : width of one FIFO word / one requester lane
//   CNT_W      : width of the FIFO occupancy count (0..FIFO_DEPTH)
//   arb_state_t: arbiter FSM states
package fifo_arb_pkg;

    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned DATA_W     = 4;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin winner selection.
// Ports:
//   req    in  N_REQ : request vector
//   rr_ptr in  PTR_W : index holding highest priority
//   valid  out 1     : at least one request is pending
//   winner out PTR_W : first requesting index at or after rr_ptr (modulo N_REQ)
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic             valid,
    output logic [PTR_W-1:0] winner
);

    // (base + offs) mod N_REQ; correct for non-power-of-two N_REQ.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int unsigned offs);
        int unsigned sum;
        sum = (32'(base) + offs) % N_REQ;
        return PTR_W'(sum);
    endfunction

    logic [N_REQ-1:0] rotated;
    logic [PTR_W-1:0] offset;

    // Rotate so that rr_ptr lands at bit 0.
    always_comb begin
        rotated = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            rotated[j] = req[wrap_add(rr_ptr, j)];
        end
    end

    // Lowest set bit of the rotated vector; scanning downward lets it win last.
    always_comb begin
        offset = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                offset = PTR_W'(j);
            end
        end
    end

    assign valid  = |rotated;
    assign winner = wrap_add(rr_ptr, 32'(offset));

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter for the write side of an 8 x 4 sync FIFO.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   req          : per-requester valid; req_data lane i = bits [4i+3:4i]
//   gnt          : one-hot lane written into the FIFO this cycle (zero when idle)
//   fifo_wr_en   : FIFO write strobe; fifo_data_in is the written word (0 when no write)
//   fifo_full    : FIFO full flag; fifo_count: registered FIFO occupancy
//   owner        : current or most recent burst owner
//   busy         : high while a burst is in progress
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned BURST_LEN = 2,
    parameter int unsigned MIN_FREE  = 1,
    localparam int unsigned PTR_W    = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        gnt,
    output logic                    fifo_wr_en,
    output logic [DATA_W-1:0]       fifo_data_in,
    input  logic                    fifo_full,
    input  logic [CNT_W-1:0]        fifo_count,
    output logic [PTR_W-1:0]        owner,
    output logic                    busy
);

    localparam logic [CNT_W-1:0] START_MAX = CNT_W'(FIFO_DEPTH - MIN_FREE);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BURST_LEN);

    arb_state_t       state_q, state_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic             pick_valid;
    logic [PTR_W-1:0] pick_idx;
    logic             wr;
    logic [PTR_W-1:0] wr_lane;
    logic [DATA_W-1:0] lane_data [N_REQ];

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            lane_data[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        wr          = 1'b0;
        wr_lane     = owner_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid && !fifo_full && (fifo_count <= START_MAX)) begin
                    wr          = 1'b1;
                    wr_lane     = pick_idx;
                    owner_d     = pick_idx;
                    burst_cnt_d = CNT_W'(1);
                    if (BURST_LEN == 1) begin
                        rr_ptr_d = next_idx(pick_idx);
                    end else begin
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                if (req[owner_q]) begin
                    // Full simply stalls the burst; there is no timeout.
                    if (!fifo_full) begin
                        wr          = 1'b1;
                        burst_cnt_d = burst_cnt_q + 1'b1;
                        if (burst_cnt_d == LAST_CNT) begin
                            state_d  = IDLE;
                            rr_ptr_d = next_idx(owner_q);
                        end
                    end
                end else begin
                    // Owner went quiet: give up the port, costing one bubble.
                    state_d  = IDLE;
                    rr_ptr_d = next_idx(owner_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reset) begin
            wr = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            gnt[i] = wr && (wr_lane == PTR_W'(i));
        end
        fifo_wr_en   = wr;
        fifo_data_in = wr ? lane_data[wr_lane] : '0;
    end

    assign owner = owner_q;
    assign busy  = (state_q == BURST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed checks of fifo_wr_arbiter.
// Three instances share req/req_data/reset:
//   a: BURST_LEN=2 MIN_FREE=1, b: BURST_LEN=4 MIN_FREE=1, c: BURST_LEN=2 MIN_FREE=3.
// Each has its own FIFO occupancy model (count/full) that the bench can preload or drain.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] req_data;

    logic [3:0] gnt_a, gnt_b, gnt_c;
    logic       wr_a, wr_b, wr_c;
    logic [3:0] dat_a, dat_b, dat_c;
    logic [1:0] own_a, own_b, own_c;
    logic       busy_a, busy_b, busy_c;

    logic [3:0] cnt [3];
    logic [3:0] ld_val [3];
    logic [2:0] ld, rd, full, wr;

    int n_cmp;
    int n_err;

    logic [3:0] exp_gnt [8];
    logic [3:0] exp_dat [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign wr = {wr_c, wr_b, wr_a};

    // FIFO occupancy model: writes from the DUT, reads/preloads from the bench.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ld[k]) cnt[k] <= ld_val[k];
            else cnt[k] <= cnt[k] + 4'(wr[k]) - 4'(rd[k] && (cnt[k] != 4'd0));
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) full[k] = (cnt[k] == 4'd8);
    end

    fifo_wr_arbiter #(.N_REQ(4), .BURST_LEN(2), .MIN_FREE(1)) dut_a (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt_a),
        .fifo_wr_en(wr_a), .fifo_data_in(dat_a), .fifo_full(full[0]), .fifo_count(cnt[0]),
        .owner(own_a), .busy(busy_a)
    );

    fifo_wr_arbiter #(.N_REQ(4), .BURST_LEN(4), .MIN_FREE(1)) dut_b (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt_b),
        .fifo_wr_en(wr_b), .fifo_data_in(dat_b), .fifo_full(full[1]), .fifo_count(cnt[1]),
        .owner(own_b), .busy(busy_b)
    );

    fifo_wr_arbiter #(.N_REQ(4), .BURST_LEN(2), .MIN_FREE(3)) dut_c (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt_c),
        .fifo_wr_en(wr_c), .fifo_data_in(dat_c), .fifo_full(full[2]), .fifo_count(cnt[2]),
        .owner(own_c), .busy(busy_c)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic [3:0] va, input logic [3:0] vb, input logic [3:0] vc);
        reset     = 1'b1;
        req       = '0;
        req_data  = '0;
        rd        = '0;
        ld        = 3'b111;
        ld_val[0] = va;
        ld_val[1] = vb;
        ld_val[2] = vc;
        tick();
        tick();
        reset = 1'b0;
        ld    = '0;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset   = 1'b1;
        req     = '0;
        req_data = '0;
        rd      = '0;
        ld      = '0;
        exp_gnt = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8};
        exp_dat = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3};

        // Reset values
        do_reset(4'd0, 4'd0, 4'd0);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt_a), 32'h0);
        chk("rst_wr", 32'(wr_a), 32'h0);
        chk("rst_data", 32'(dat_a), 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_owner", 32'(own_a), 32'h0);
        chk("rst_rr", 32'(dut_a.rr_ptr_q), 32'h0);
        tick();

        // Single requester 2: A then B, then back to IDLE with rr_ptr=3
        req = 4'b0100;
        req_data = 16'h0A00;
        @(negedge clk);
        chk("t1_c0_gnt", 32'(gnt_a), 32'h4);
        chk("t1_c0_data", 32'(dat_a), 32'hA);
        chk("t1_c0_busy", 32'(busy_a), 32'h0);
        tick();
        req_data = 16'h0B00;
        @(negedge clk);
        chk("t1_c1_gnt", 32'(gnt_a), 32'h4);
        chk("t1_c1_data", 32'(dat_a), 32'hB);
        chk("t1_c1_busy", 32'(busy_a), 32'h1);
        chk("t1_c1_owner", 32'(own_a), 32'h2);
        tick();
        req = 4'b0000;
        @(negedge clk);
        chk("t1_c2_gnt", 32'(gnt_a), 32'h0);
        chk("t1_c2_busy", 32'(busy_a), 32'h0);
        chk("t1_c2_rr", 32'(dut_a.rr_ptr_q), 32'h3);
        tick();

        // All four continuously: 0,0,1,1,2,2,3,3 back-to-back, then full
        do_reset(4'd0, 4'd0, 4'd0);
        req = 4'b1111;
        req_data = 16'h3210;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("t2_gnt%0d", k), 32'(gnt_a), 32'(exp_gnt[k]));
            chk($sformatf("t2_data%0d", k), 32'(dat_a), 32'(exp_dat[k]));
            tick();
        end
        @(negedge clk);
        chk("t2_full", 32'(full[0]), 32'h1);
        chk("t2_full_gnt", 32'(gnt_a), 32'h0);
        chk("t2_full_wr", 32'(wr_a), 32'h0);
        tick();

        // Full mid-burst: prefill 7, owner 1 writes once, stalls, resumes after a read
        do_reset(4'd7, 4'd0, 4'd0);
        req = 4'b0010;
        req_data = 16'h0050;
        @(negedge clk);
        chk("t3_c0_gnt", 32'(gnt_a), 32'h2);
        chk("t3_c0_data", 32'(dat_a), 32'h5);
        tick();
        req_data = 16'h0060;
        rd = 3'b001;
        @(negedge clk);
        chk("t3_stall_gnt", 32'(gnt_a), 32'h0);
        chk("t3_stall_wr", 32'(wr_a), 32'h0);
        chk("t3_stall_busy", 32'(busy_a), 32'h1);
        tick();
        rd = 3'b000;
        @(negedge clk);
        chk("t3_c2_gnt", 32'(gnt_a), 32'h2);
        chk("t3_c2_data", 32'(dat_a), 32'h6);
        chk("t3_c2_busy", 32'(busy_a), 32'h1);
        tick();
        req = 4'b0000;
        @(negedge clk);
        chk("t3_c3_busy", 32'(busy_a), 32'h0);
        chk("t3_c3_rr", 32'(dut_a.rr_ptr_q), 32'h2);
        tick();

        // Early release with BURST_LEN=4: bubble, then requester 1
        do_reset(4'd0, 4'd0, 4'd0);
        req = 4'b0011;
        req_data = 16'h0093;
        @(negedge clk);
        chk("t4_c0_gnt", 32'(gnt_b), 32'h1);
        chk("t4_c0_data", 32'(dat_b), 32'h3);
        tick();
        req = 4'b0010;
        @(negedge clk);
        chk("t4_bubble_gnt", 32'(gnt_b), 32'h0);
        chk("t4_bubble_wr", 32'(wr_b), 32'h0);
        chk("t4_bubble_busy", 32'(busy_b), 32'h1);
        tick();
        @(negedge clk);
        chk("t4_c2_gnt", 32'(gnt_b), 32'h2);
        chk("t4_c2_data", 32'(dat_b), 32'h9);
        chk("t4_c2_busy", 32'(busy_b), 32'h0);
        tick();
        req = 4'b0000;

        // Reset in the second burst cycle
        do_reset(4'd0, 4'd0, 4'd0);
        req = 4'b0100;
        req_data = 16'h0400;
        @(negedge clk);
        chk("t5_c0_gnt", 32'(gnt_a), 32'h4);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("t5_rst_wr", 32'(wr_a), 32'h0);
        chk("t5_rst_gnt", 32'(gnt_a), 32'h0);
        chk("t5_rst_data", 32'(dat_a), 32'h0);
        tick();
        @(negedge clk);
        chk("t5_after_busy", 32'(busy_a), 32'h0);
        chk("t5_after_gnt", 32'(gnt_a), 32'h0);
        chk("t5_after_rr", 32'(dut_a.rr_ptr_q), 32'h0);
        chk("t5_after_owner", 32'(own_a), 32'h0);
        tick();
        reset = 1'b0;
        req = 4'b0000;

        // MIN_FREE=3: count 6 blocks, count 5 grants in the same cycle
        do_reset(4'd0, 4'd0, 4'd6);
        req = 4'b0001;
        req_data = 16'h0007;
        @(negedge clk);
        chk("t6_cnt6_gnt", 32'(gnt_c), 32'h0);
        chk("t6_cnt6_wr", 32'(wr_c), 32'h0);
        rd = 3'b100;
        tick();
        rd = 3'b000;
        @(negedge clk);
        chk("t6_cnt5_gnt", 32'(gnt_c), 32'h1);
        chk("t6_cnt5_data", 32'(dat_c), 32'h7);
        tick();
        req = 4'b0000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
